// File: rtl/alu_ex_pipe_pkg.sv
// Shared definitions for the ALU execute pipe.
//   funct3_e    : ALU operation selector (low three opcode bits)
//   res_entry_t : one result as it travels through the pipe and result queue
//   TAG_W       : storage width of the ROB tag inside res_entry_t (ROB_AW <= TAG_W)
package alu_ex_pipe_pkg;

    localparam int TAG_W = 8;

    typedef enum logic [2:0] {
        FUNCT3_ADD  = 3'b000,   // opcode[3]=1 selects subtract
        FUNCT3_SLL  = 3'b001,
        FUNCT3_SLT  = 3'b010,
        FUNCT3_SLTU = 3'b011,
        FUNCT3_XOR  = 3'b100,
        FUNCT3_SRL  = 3'b101,   // opcode[3]=1 selects arithmetic shift
        FUNCT3_OR   = 3'b110,
        FUNCT3_AND  = 3'b111
    } funct3_e;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] rob_addr;
        logic             addr_cal;
        logic             con_branch_comp;
    } res_entry_t;

endpackage

// File: rtl/alu_ex_pipe_if.sv
// Issue / broadcast bundle of the ALU execute pipe.
//   slave  : the pipe's view (issue inputs and flush in, busy and broadcast head out)
//   master : the issuing / consuming side
interface alu_ex_pipe_if #(
    parameter int ROB_AW = 3
);
    logic              i_flush;
    logic              i_ex_en;
    logic              o_busy;
    logic [ROB_AW-1:0] i_rob_addr;
    logic [31:0]       i_rs1_value;
    logic [31:0]       i_rs2_value;
    logic [4:0]        i_alu_opcode;
    logic              i_addr_cal;
    logic              i_con_branch_comp;
    logic              o_broadcast_ready;
    logic              i_broadcast_en;
    logic [31:0]       o_broadcast_out;
    logic [ROB_AW-1:0] o_broadcast_rob_addr;
    logic              o_broadcast_addr_cal;
    logic              o_broadcast_con_branch_comp;

    modport slave (
        input  i_flush, i_ex_en, i_rob_addr, i_rs1_value, i_rs2_value, i_alu_opcode,
               i_addr_cal, i_con_branch_comp, i_broadcast_en,
        output o_busy, o_broadcast_ready, o_broadcast_out, o_broadcast_rob_addr,
               o_broadcast_addr_cal, o_broadcast_con_branch_comp
    );

    modport master (
        output i_flush, i_ex_en, i_rob_addr, i_rs1_value, i_rs2_value, i_alu_opcode,
               i_addr_cal, i_con_branch_comp, i_broadcast_en,
        input  o_busy, o_broadcast_ready, o_broadcast_out, o_broadcast_rob_addr,
               o_broadcast_addr_cal, o_broadcast_con_branch_comp
    );
endinterface

// File: rtl/alu_ex_pipe_alu.sv
// Combinational integer ALU.
//   alu_opcode : [2:0] funct3, [3] sub / arithmetic-shift modifier, [4] pass rs2 through
//   rs1_value, rs2_value : operands
//   result     : 32-bit result
module alu_ex_pipe_alu
    import alu_ex_pipe_pkg::*;
(
    input  logic [4:0]  alu_opcode,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        if (alu_opcode[4]) begin
            result = rs2_value;
        end else begin
            case (funct3_e'(alu_opcode[2:0]))
                FUNCT3_ADD:  result = alu_opcode[3] ? rs1_value - rs2_value
                                                    : rs1_value + rs2_value;
                FUNCT3_SLL:  result = rs1_value << rs2_value[4:0];
                FUNCT3_SLT:  result = {31'b0, $signed(rs1_value) < $signed(rs2_value)};
                FUNCT3_SLTU: result = {31'b0, rs1_value < rs2_value};
                FUNCT3_XOR:  result = rs1_value ^ rs2_value;
                FUNCT3_SRL:  result = alu_opcode[3] ? $unsigned($signed(rs1_value) >>> rs2_value[4:0])
                                                    : rs1_value >> rs2_value[4:0];
                FUNCT3_OR:   result = rs1_value | rs2_value;
                FUNCT3_AND:  result = rs1_value & rs2_value;
            endcase
        end
    end

endmodule

// File: rtl/alu_ex_pipe.sv
// ALU execute pipe: fixed-latency ALU pipeline feeding an in-order FWFT result queue.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : alu_ex_pipe_if.slave -- issue request/operands, flush, busy,
//               broadcast head (ready/data/tag/flags) and pop strobe
// Parameters: ROB_AW tag width, LAT issue-to-queue latency (1..8),
// RESQ_DEPTH result-queue entries (2..16).
module alu_ex_pipe
    import alu_ex_pipe_pkg::*;
#(
    parameter int ROB_AW     = 3,
    parameter int LAT        = 3,
    parameter int RESQ_DEPTH = 4
) (
    input logic          clk,
    input logic          rstn,
    alu_ex_pipe_if.slave bus
);

    localparam int CW = $clog2(RESQ_DEPTH + 1);
    localparam int PW = $clog2(RESQ_DEPTH);

    if (LAT < 1 || LAT > 8)                 begin : g_bad_lat   $error("LAT out of range");        end
    if (RESQ_DEPTH < 2 || RESQ_DEPTH > 16)  begin : g_bad_depth $error("RESQ_DEPTH out of range"); end
    if (ROB_AW > TAG_W)                     begin : g_bad_tag   $error("ROB_AW exceeds TAG_W");     end

    logic [31:0]   alu_result;
    res_entry_t    issue_entry;
    res_entry_t    pipe_q [LAT];
    logic [LAT-1:0] pipe_vld;
    res_entry_t    mem [RESQ_DEPTH];
    res_entry_t    head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] inflight_cnt, queue_cnt;
    logic [CW:0]   credit_used;
    logic          issue, push, pop, queue_nempty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    alu_ex_pipe_alu alu_i (
        .alu_opcode (bus.i_alu_opcode),
        .rs1_value  (bus.i_rs1_value),
        .rs2_value  (bus.i_rs2_value),
        .result     (alu_result)
    );

    // Every op in flight already owns a queue slot, so the pipe exit never
    // meets a full queue and the pipe never has to stall.
    assign credit_used  = {1'b0, inflight_cnt} + {1'b0, queue_cnt};
    assign bus.o_busy   = credit_used >= (CW+1)'(RESQ_DEPTH);
    assign issue        = bus.i_ex_en & ~bus.o_busy & ~bus.i_flush;
    assign push         = pipe_vld[LAT-1];
    assign queue_nempty = queue_cnt != '0;
    assign pop          = bus.i_broadcast_en & queue_nempty;

    always_comb begin
        issue_entry                 = '0;
        issue_entry.data            = alu_result;
        issue_entry.rob_addr        = TAG_W'(bus.i_rob_addr);
        issue_entry.addr_cal        = bus.i_addr_cal;
        issue_entry.con_branch_comp = bus.i_con_branch_comp;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld <= '0;
        end else if (bus.i_flush) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // Payload is qualified by pipe_vld / queue_cnt, so it needs no reset.
    always_ff @(posedge clk) begin
        pipe_q[0] <= issue_entry;
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        if (push && !bus.i_flush) mem[wptr] <= pipe_q[LAT-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr         <= '0;
            rptr         <= '0;
            queue_cnt    <= '0;
            inflight_cnt <= '0;
        end else if (bus.i_flush) begin
            wptr         <= '0;
            rptr         <= '0;
            queue_cnt    <= '0;
            inflight_cnt <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            queue_cnt    <= queue_cnt + CW'(push) - CW'(pop);
            inflight_cnt <= inflight_cnt + CW'(issue) - CW'(push);
        end
    end

    assign head = queue_nempty ? mem[rptr] : '0;

    assign bus.o_broadcast_ready           = queue_nempty;
    assign bus.o_broadcast_out             = head.data;
    assign bus.o_broadcast_rob_addr        = head.rob_addr[ROB_AW-1:0];
    assign bus.o_broadcast_addr_cal        = head.addr_cal;
    assign bus.o_broadcast_con_branch_comp = head.con_branch_comp;

    // Tag storage is wider than ROB_AW; the upper bits are always zero.
    if (ROB_AW < TAG_W) begin : g_tag_pad
        logic unused_tag_bits;
        assign unused_tag_bits = |head.rob_addr[TAG_W-1:ROB_AW];
    end

endmodule
